// File: rtl/ajuste_fecha_pkg.sv
// fecha_pkg: shared types, field codes, BCD month constants and BCD step helpers for ajuste_fecha
package fecha_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT, HOLD} estado_t;
  localparam logic [1:0] CAMPO_DIA = 2'd0;
  localparam logic [1:0] CAMPO_MES = 2'd1;
  localparam logic [1:0] CAMPO_YEAR = 2'd2;
  localparam logic [7:0] MES_ENE = 8'h01;
  localparam logic [7:0] MES_FEB = 8'h02;
  localparam logic [7:0] MES_ABR = 8'h04;
  localparam logic [7:0] MES_JUN = 8'h06;
  localparam logic [7:0] MES_SEP = 8'h09;
  localparam logic [7:0] MES_NOV = 8'h11;
  localparam logic [7:0] MES_DIC = 8'h12;
  localparam int unsigned HOLD_CYCLES_DEF = 112;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction
endpackage

// File: rtl/ajuste_fecha_if.sv
// ajuste_fecha_if: edit buttons in, BCD date / field / commit handshake out
//   master: drives edit_en and btn_*; reads dia, mes, year, campo, chs, busy
//   slave : the date editor side
interface ajuste_fecha_if;
  logic edit_en, btn_up, btn_down, btn_right, btn_left, btn_save;
  logic [7:0] dia, mes, year;
  logic [1:0] campo;
  logic chs, busy;
  modport master(
    output edit_en, btn_up, btn_down, btn_right, btn_left, btn_save,
    input dia, mes, year, campo, chs, busy
  );
  modport slave(
    input edit_en, btn_up, btn_down, btn_right, btn_left, btn_save,
    output dia, mes, year, campo, chs, busy
  );
endinterface

// File: rtl/ajuste_fecha_dias_del_mes.sv
// dias_del_mes: combinational BCD month/year -> last legal BCD day of that month
//   mes, year : BCD inputs (year 00..99 read as 2000-2099)
//   max_dia   : 28/29/30/31 in BCD
//   AJUSTE_FECHA_LEAP_EN defined builds the leap-year rule; otherwise February is always 28
module dias_del_mes
  import fecha_pkg::*;
(
  input  logic [7:0] mes,
  input  logic [7:0] year,
  output logic [7:0] max_dia
);
  logic [7:0] feb;
  logic unused_year;
  assign unused_year = ^year;
`ifdef AJUSTE_FECHA_LEAP_EN
  logic bis;
  // divisible by 4 in BCD: even tens need units 0/4/8, odd tens need units 2/6
  assign bis = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                       : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
  assign feb = bis ? 8'h29 : 8'h28;
`else
  assign feb = 8'h28;
`endif
  always_comb max_dia = mes == MES_FEB ? feb :
                        (mes == MES_ABR || mes == MES_JUN || mes == MES_SEP || mes == MES_NOV) ? 8'h30 : 8'h31;
endmodule

// File: rtl/ajuste_fecha.sv
// ajuste_fecha: BCD date editor that commits dia/mes/year to the RTC writer with a one-cycle chs
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ajuste_fecha_if.slave (edit_en, btn_* in; dia, mes, year, campo, chs, busy out)
//   Optional macro AJUSTE_FECHA_LEAP_EN enables leap-year February (see dias_del_mes)
module ajuste_fecha
  import fecha_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter logic [7:0] DIA_INIT = 8'h01,
  parameter logic [7:0] MES_INIT = 8'h01,
  parameter logic [7:0] YEAR_INIT = 8'h16
) (
  input logic clock,
  input logic reset,
  ajuste_fecha_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYCLES);
  estado_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] dia_q, mes_q, year_q, dia_n, mes_n, year_n, max_n;
  logic [1:0] campo_q, campo_n;
  logic edit, up, dn, rt, lt, hold_last;
  // one action per cycle: save > up > down > right > left
  assign edit = state == EDIT && bus.edit_en;
  assign up = edit && !bus.btn_save && bus.btn_up;
  assign dn = edit && !bus.btn_save && !bus.btn_up && bus.btn_down;
  assign rt = edit && !bus.btn_save && !bus.btn_up && !bus.btn_down && bus.btn_right;
  assign lt = edit && !bus.btn_save && !bus.btn_up && !bus.btn_down && !bus.btn_right && bus.btn_left;
  assign hold_last = cnt == CW'(HOLD_CYCLES - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.edit_en ? EDIT : IDLE;
      EDIT: state_n = !bus.edit_en ? IDLE : bus.btn_save ? COMMIT : EDIT;
      COMMIT: state_n = HOLD;
      HOLD: state_n = !hold_last ? HOLD : bus.edit_en ? EDIT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // max_n is taken from the new month/year, so it also serves the dia wrap when mes/year are untouched
  dias_del_mes u_dias (.mes(mes_n), .year(year_n), .max_dia(max_n));
  always_comb begin
    mes_n = mes_q;
    year_n = year_q;
    dia_n = dia_q;
    campo_n = campo_q;
    mes_n = campo_q != CAMPO_MES ? mes_q :
            up ? (mes_q == MES_DIC ? MES_ENE : bcd_inc(mes_q)) :
            dn ? (mes_q == MES_ENE ? MES_DIC : bcd_dec(mes_q)) : mes_q;
    year_n = campo_q != CAMPO_YEAR ? year_q :
             up ? (year_q == 8'h99 ? 8'h00 : bcd_inc(year_q)) :
             dn ? (year_q == 8'h00 ? 8'h99 : bcd_dec(year_q)) : year_q;
    dia_n = campo_q != CAMPO_DIA ? (dia_q > max_n ? max_n : dia_q) :
            up ? (dia_q >= max_n ? 8'h01 : bcd_inc(dia_q)) :
            dn ? (dia_q == 8'h01 ? max_n : bcd_dec(dia_q)) : dia_q;
    campo_n = rt ? (campo_q == CAMPO_YEAR ? CAMPO_DIA : campo_q + 2'd1) :
              lt ? (campo_q == CAMPO_DIA ? CAMPO_YEAR : campo_q - 2'd1) : campo_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dia_q <= DIA_INIT;
      mes_q <= MES_INIT;
      year_q <= YEAR_INIT;
      campo_q <= CAMPO_DIA;
    end else begin
      state <= state_n;
      cnt <= state == HOLD ? cnt + CW'(1) : '0;
      dia_q <= dia_n;
      mes_q <= mes_n;
      year_q <= year_n;
      campo_q <= campo_n;
    end
  end
  assign bus.dia = dia_q;
  assign bus.mes = mes_q;
  assign bus.year = year_q;
  assign bus.campo = campo_q;
  assign bus.chs = state == COMMIT;
  assign bus.busy = state == COMMIT || state == HOLD;
endmodule

// File: tb/tb_ajuste_fecha.sv
// tb_ajuste_fecha: scoreboard bench for ajuste_fecha (date edits, wraps, clamping, commit/hold, async reset)
module tb_ajuste_fecha;
  typedef struct packed {
    logic [7:0] d, m, y;
    logic [1:0] c;
  } snap_t;
`ifdef AJUSTE_FECHA_LEAP_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_d = 1, m_m = 1, m_y = 16, m_c = 0;
  snap_t exp_q[$];
  snap_t chs_q[$];
  ajuste_fecha_if bus ();
  ajuste_fecha dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  function automatic logic [7:0] i2b(input int i);
    return {4'(i / 10), 4'(i % 10)};
  endfunction
  function automatic int mdays(input int m, input int y);
    if (m == 2) return (LEAP && y % 4 == 0) ? 29 : 28;
    return (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
  endfunction
  function automatic snap_t cur();
    return {i2b(m_d), i2b(m_m), i2b(m_y), 2'(m_c)};
  endfunction
  function automatic void model(input logic [4:0] b);
    int md;
    int dir;
    dir = b[3] ? 1 : -1;
    if (b[4]) chs_q.push_back(cur());
    else if (b[3] || b[2]) begin
      if (m_c == 0) begin
        md = mdays(m_m, m_y);
        m_d = dir > 0 ? (m_d >= md ? 1 : m_d + 1) : (m_d == 1 ? md : m_d - 1);
      end else begin
        if (m_c == 1) m_m = dir > 0 ? m_m % 12 + 1 : (m_m == 1 ? 12 : m_m - 1);
        else m_y = (m_y + dir + 100) % 100;
        md = mdays(m_m, m_y);
        if (m_d > md) m_d = md;
      end
    end
    else if (b[1]) m_c = (m_c + 1) % 3;
    else if (b[0]) m_c = (m_c + 2) % 3;
  endfunction
  // b = {save, up, down, right, left}; apply=0 when the DUT must ignore the buttons
  task automatic press(input logic [4:0] b, input bit apply);
    snap_t e, o;
    if (apply) model(b);
    exp_q.push_back(cur());
    {bus.btn_save, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left} = b;
    @(posedge clock);
    #1;
    {bus.btn_save, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left} = '0;
    e = exp_q.pop_front();
    o = {bus.dia, bus.mes, bus.year, bus.campo};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL press %b: got %h/%h/%h campo %0d, expected %h/%h/%h campo %0d",
               b, o.d, o.m, o.y, o.c, e.d, e.m, e.y, e.c);
    end
  endtask
  always @(negedge clock) begin
    if (reset && bus.chs === 1'b1) begin
      checks++;
      if (chs_q.size() == 0) begin
        errors++;
        $display("FAIL chs_unexpected: chs=1, expected 0");
      end else begin
        snap_t e;
        e = chs_q.pop_front();
        if ({bus.dia, bus.mes, bus.year} !== {e.d, e.m, e.y}) begin
          errors++;
          $display("FAIL chs_date: got %h/%h/%h, expected %h/%h/%h", bus.dia, bus.mes, bus.year, e.d, e.m, e.y);
        end
      end
    end
  end
  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.dia, bus.mes, bus.year} !== 24'h010116) begin
      errors++;
      $display("FAIL reset_date: got %h/%h/%h, expected 01/01/16", bus.dia, bus.mes, bus.year);
    end
    checks++;
    if (bus.campo !== 2'd0) begin
      errors++;
      $display("FAIL reset_campo: got %0d, expected 0", bus.campo);
    end
    checks++;
    if ({bus.chs, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_chs_busy: got %b%b, expected 00", bus.chs, bus.busy);
    end
    reset = 1'b1;
  endtask
  task automatic test_commit();
    int n;
    bus.edit_en = 1'b1;
    @(posedge clock);
    #1;
    press(5'b10000, 1'b1);
    checks++;
    if ({bus.chs, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL commit_pulse: chs/busy %b%b, expected 11", bus.chs, bus.busy);
    end
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      if (bus.busy !== 1'b1) break;
      n++;
      checks++;
      if (bus.chs !== 1'b0 || {bus.dia, bus.mes, bus.year, bus.campo} !== cur()) begin
        errors++;
        $display("FAIL hold_stable: chs %b date %h/%h/%h, expected chs 0 date %h/%h/%h",
                 bus.chs, bus.dia, bus.mes, bus.year, cur().d, cur().m, cur().y);
      end
    end
    checks++;
    if (n != 113) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, expected 113", n);
    end
  endtask
  task automatic test_clamp();
    press(5'b00100, 1'b1);
    press(5'b00010, 1'b1);
    press(5'b01000, 1'b1);
    checks++;
    if ({bus.dia, bus.mes} !== {(LEAP ? 8'h29 : 8'h28), 8'h02}) begin
      errors++;
      $display("FAIL clamp_feb: got %h/%h, expected %h/02", bus.dia, bus.mes, LEAP ? 8'h29 : 8'h28);
    end
    press(5'b00010, 1'b1);
    press(5'b01000, 1'b1);
    checks++;
    if ({bus.dia, bus.year} !== 16'h2817) begin
      errors++;
      $display("FAIL clamp_year: got dia %h year %h, expected 28 17", bus.dia, bus.year);
    end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 18; i++) press(5'b00100, 1'b1);
    press(5'b01000, 1'b1);
    checks++;
    if (bus.year !== 8'h00) begin
      errors++;
      $display("FAIL wrap_year: got %h, expected 00", bus.year);
    end
    press(5'b00001, 1'b1);
    press(5'b00100, 1'b1);
    press(5'b00100, 1'b1);
    checks++;
    if (bus.mes !== 8'h12) begin
      errors++;
      $display("FAIL wrap_mes: got %h, expected 12", bus.mes);
    end
    for (int i = 0; i < 4; i++) press(5'b01000, 1'b1);
    press(5'b00001, 1'b1);
    for (int i = 0; i < 28; i++) press(5'b00100, 1'b1);
    checks++;
    if ({bus.dia, bus.mes} !== 16'h3004) begin
      errors++;
      $display("FAIL wrap_dia: got %h/%h, expected 30/04", bus.dia, bus.mes);
    end
    press(5'b00001, 1'b1);
    checks++;
    if (bus.campo !== 2'd2) begin
      errors++;
      $display("FAIL wrap_campo: got %0d, expected 2", bus.campo);
    end
  endtask
  task automatic test_priority();
    press(5'b01010, 1'b1);
    checks++;
    if ({bus.year, bus.campo} !== {8'h01, 2'd2}) begin
      errors++;
      $display("FAIL prio_up_right: got year %h campo %0d, expected 01 2", bus.year, bus.campo);
    end
    press(5'b00101, 1'b1);
    press(5'b00011, 1'b1);
  endtask
  task automatic test_hold_ignore();
    press(5'b11000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) bus.edit_en = 1'b0;
      press(5'($urandom_range(1, 31)), 1'b0);
    end
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_timeout: busy %b, expected 0", bus.busy);
    end
    bus.edit_en = 1'b1;
    press(5'b01000, 1'b0);
    press(5'b01000, 1'b1);
  endtask
  task automatic test_async_reset();
    press(5'b00010, 1'b1);
    press(5'b10000, 1'b1);
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.chs, bus.busy, bus.campo} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_ctl: chs %b busy %b campo %0d, expected 0 0 0", bus.chs, bus.busy, bus.campo);
    end
    checks++;
    if ({bus.dia, bus.mes, bus.year} !== 24'h010116) begin
      errors++;
      $display("FAIL async_reset_date: got %h/%h/%h, expected 01/01/16", bus.dia, bus.mes, bus.year);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    m_d = 1;
    m_m = 1;
    m_y = 16;
    m_c = 0;
    @(posedge clock);
    #1;
    press(5'b01000, 1'b1);
    checks++;
    if (chs_q.size() != 0) begin
      errors++;
      $display("FAIL chs_missing: %0d pulses outstanding, expected 0", chs_q.size());
    end
  endtask
  initial begin
    bus.edit_en = 1'b0;
    {bus.btn_save, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left} = '0;
    test_reset();
    test_commit();
    test_clamp();
    test_wrap();
    test_priority();
    test_hold_ignore();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
